host_ctrl_parser: RTL

Receives the host command byte stream from the USB FIFO interface and decodes fixed-length control frames. Frames are 8 bytes long and checksum-protected. Each valid frame commits the receive frequency and control flags atomically. These values drive `adc_init`:
- `run` is the ADC standby/active request.
- `freq` is the receive frequency in Hz divided by 65536.

A watchdog forces `run` low if the host stops sending valid frames, which parks the ADC in standby.

---
 rtl/host_ctrl_parser.sv | 120 ++++++++++++
 1 files changed

// File: rtl/host_ctrl_parser.sv
// Host control-frame parser: hunts for AA 55, gathers C/F3..F0, verifies the XOR checksum
// and commits ctrl/freq atomically. A watchdog drops run when valid frames stop arriving.
module host_ctrl_parser #(
   parameter int TIMEOUT     = 1024,
   parameter int WDOG_CYCLES = 1 << 24
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        run,
   output logic [31:0] freq_hz,
   output logic [15:0] freq,
   output logic [7:0]  ctrl,
   output logic        frame_ok,
   output logic        frame_err,
   output logic        wdog_trip
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int WD_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

   typedef enum logic [1:0] {HUNT0, HUNT1, PAYLOAD, CHECK} state_t;

   state_t            state_reg;
   logic [2:0]        idx_reg;
   logic [7:0]        shadow_reg [0:4];
   logic [7:0]        csum_reg;
   logic [TMO_W-1:0]  tmo_reg;
   logic [WD_W-1:0]   wdog_reg;
   logic              wdog_expired_reg;
   logic              commit;

   assign commit = in_valid && (state_reg == CHECK) && (in_data == csum_reg);
   // Both halves come from the same register, so freq can never be torn against freq_hz.
   assign freq   = freq_hz[31:16];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= HUNT0;
         idx_reg          <= '0;
         csum_reg         <= '0;
         tmo_reg          <= '0;
         wdog_reg         <= '0;
         wdog_expired_reg <= 1'b0;
         for (int i = 0; i < 5; i++) shadow_reg[i] <= '0;
         run              <= 1'b0;
         freq_hz          <= '0;
         ctrl             <= '0;
         frame_ok         <= 1'b0;
         frame_err        <= 1'b0;
         wdog_trip        <= 1'b0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         wdog_trip <= 1'b0;

         if (in_valid) begin
            tmo_reg <= '0;
            case (state_reg)
               HUNT0: begin
                  if (in_data == 8'hAA) state_reg <= HUNT1;
               end
               HUNT1: begin
                  if (in_data == 8'h55) begin
                     state_reg <= PAYLOAD;
                     idx_reg   <= '0;
                     csum_reg  <= '0;
                  end else if (in_data != 8'hAA) begin
                     state_reg <= HUNT0;
                  end
               end
               PAYLOAD: begin
                  shadow_reg[idx_reg] <= in_data;
                  csum_reg            <= csum_reg ^ in_data;
                  if (idx_reg == 3'd4) state_reg <= CHECK;
                  else                 idx_reg   <= idx_reg + 3'd1;
               end
               CHECK: begin
                  if (commit) begin
                     ctrl     <= shadow_reg[0];
                     freq_hz  <= {shadow_reg[1], shadow_reg[2], shadow_reg[3], shadow_reg[4]};
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state_reg <= HUNT0;
               end
               default: state_reg <= HUNT0;
            endcase
         end else if (state_reg != HUNT0) begin
            // A byte arriving on the limit cycle takes the branch above, so it always wins.
            if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
               frame_err <= 1'b1;
               state_reg <= HUNT0;
               tmo_reg   <= '0;
               for (int i = 0; i < 5; i++) shadow_reg[i] <= '0;
            end else begin
               tmo_reg <= tmo_reg + TMO_W'(1);
            end
         end

         // Commit has priority over expiry; the counter saturates so the trip pulses once.
         if (commit) begin
            wdog_reg         <= '0;
            wdog_expired_reg <= 1'b0;
            run              <= shadow_reg[0][0];
         end else if (wdog_reg == WD_W'(WDOG_CYCLES - 1)) begin
            if (!wdog_expired_reg) begin
               run              <= 1'b0;
               wdog_trip        <= 1'b1;
               wdog_expired_reg <= 1'b1;
            end
         end else begin
            wdog_reg <= wdog_reg + WD_W'(1);
         end
      end
   end

endmodule
